// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli fetch front-end
package idli_pkg;
  typedef logic [3:0] sqi_data_t;
  typedef enum logic [2:0] {
    FCH_IDLE,
    FCH_CMD,
    FCH_ADDR,
    FCH_DUMMY,
    FCH_DATA
  } fch_state_t;
  localparam int SQI_ADDR_NIBBLES = 6;
endpackage

// File: rtl/idli_sqi_fetch_m.sv
// idli_sqi_fetch_m: SQI SRAM sequential-read fetch front-end streaming nibbles to decode
module idli_sqi_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DUMMY_CYCLES = 2,
  parameter logic [7:0]  READ_CMD     = 8'h03
) (
  input  logic        i_fch_gck,
  input  logic        i_fch_rst_n,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic        o_fch_sqi_cs_n,
  output sqi_data_t   o_fch_sqi_out,
  output logic        o_fch_sqi_oe,
  input  sqi_data_t   i_fch_sqi_in,
  output sqi_data_t   o_fch_enc,
  output logic        o_fch_enc_vld,
  output logic [15:0] o_fch_pc
);
  fch_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  nib_q;
  logic [15:0] pc_q, pc_d;
  logic [23:0] addr_d;
  logic        cs_n_d, oe_d, vld_q;
  sqi_data_t   out_d;
  // Next state, counter, pc and pad values; pad outputs are registered from these
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    pc_d    = (state_q == FCH_DATA && nib_q == 2'd3) ? pc_q + 16'd1 : pc_q;
    case (state_q)
      FCH_IDLE: begin
        state_d = FCH_CMD;
        cnt_d   = 8'd1;
      end
      FCH_CMD: if (cnt_q == 8'd0) begin
        state_d = FCH_ADDR;
        cnt_d   = 8'(SQI_ADDR_NIBBLES - 1);
      end
      FCH_ADDR: if (cnt_q == 8'd0) begin
        state_d = FCH_DUMMY;
        cnt_d   = 8'(DUMMY_CYCLES - 1);
      end
      FCH_DUMMY: if (cnt_q == 8'd0) begin
        state_d = FCH_DATA;
        cnt_d   = 8'd0;
      end
      default: cnt_d = 8'd0;
    endcase
    if (i_fch_redirect) begin
      state_d = FCH_IDLE;
      pc_d    = i_fch_redirect_pc;
      cnt_d   = 8'd0;
    end
    addr_d = {7'b0, pc_d, 1'b0};
    cs_n_d = state_d == FCH_IDLE;
    oe_d   = state_d == FCH_CMD || state_d == FCH_ADDR;
    out_d  = state_d == FCH_CMD  ? (cnt_d[0] ? READ_CMD[7:4] : READ_CMD[3:0]) :
             state_d == FCH_ADDR ? sqi_data_t'(addr_d >> {cnt_d[2:0], 2'b00}) : '0;
  end
  // State, sequencing counter, pc tracking and registered pad outputs
  always_ff @(posedge i_fch_gck or negedge i_fch_rst_n)
    if (!i_fch_rst_n) begin
      state_q        <= FCH_IDLE;
      cnt_q          <= 8'd0;
      nib_q          <= 2'd0;
      pc_q           <= RESET_PC;
      o_fch_sqi_cs_n <= 1'b1;
      o_fch_sqi_oe   <= 1'b0;
      o_fch_sqi_out  <= '0;
      vld_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      nib_q          <= (state_q == FCH_DATA && !i_fch_redirect) ? nib_q + 2'd1 : 2'd0;
      pc_q           <= pc_d;
      o_fch_sqi_cs_n <= cs_n_d;
      o_fch_sqi_oe   <= oe_d;
      o_fch_sqi_out  <= out_d;
      vld_q          <= state_d == FCH_DATA;
    end
  assign o_fch_enc     = i_fch_sqi_in;
  assign o_fch_enc_vld = vld_q & ~i_fch_redirect;
  assign o_fch_pc      = pc_q;
endmodule

// File: doc/idli_sqi_fetch_m.md
Name: idli_sqi_fetch_m

Overview: Instruction fetch front-end that drives a serial quad-I/O (SQI) SRAM and streams instruction nibbles into decode at 4b per cycle. It produces the decoder's encoding and valid inputs and tracks the fetch PC. On a redirect from execute it tears down the current SQI read and starts a new sequential read at the target PC. It sits between the SQI pads and decode.

Parameters:
RESET_PC, 16'h0000, word address fetched first after reset.
DUMMY_CYCLES, 2, SQI dummy nibble cycles between address and read data (min 1).
READ_CMD, 8'h03, SQI read command byte.

Ports:
i_fch_gck  input  1  clock.
i_fch_rst_n  input  1  reset.
i_fch_redirect  input  1  execute redirect; restart fetch at i_fch_redirect_pc.
i_fch_redirect_pc  input  16  target word address.
o_fch_sqi_cs_n  output  1  SRAM chip select, active low.
o_fch_sqi_out  output  4  nibble driven to SRAM (sqi_data_t).
o_fch_sqi_oe  output  1  pad output enable for o_fch_sqi_out.
i_fch_sqi_in  input  4  nibble returned by SRAM (sqi_data_t).
o_fch_enc  output  4  instruction nibble to decode (sqi_data_t).
o_fch_enc_vld  output  1  o_fch_enc valid.
o_fch_pc  output  16  word address of the instruction whose nibble is on o_fch_enc.

Behaviour:
- Interface: one clock, i_fch_gck; reset i_fch_rst_n is asynchronous, active-low.
- Reset values: state IDLE; cs_n=1, sqi_oe=0, sqi_out=0, enc_vld=0, nibble count=0, pc=RESET_PC.
- States: IDLE -> CMD (2 cycles) -> ADDR (6 cycles) -> DUMMY (DUMMY_CYCLES) -> DATA (until redirect). A single down-counter sequences each state.
- IDLE: cs_n=1 for exactly one cycle. This guarantees the minimum CS-high time between reads.
- CMD: cs_n=0, oe=1. Drive READ_CMD[7:4], then READ_CMD[3:0].
- ADDR: cs_n=0, oe=1. Byte address is {7'b0, pc, 1'b0}, 24b, driven MSB nibble first.
- DUMMY: cs_n=0, oe=0, sqi_out=0.
- DATA: cs_n=0, oe=0. o_fch_enc = i_fch_sqi_in, passed combinationally; enc_vld=1.
- Nibble order in DATA: memory is big-endian (high byte at even address), so nibbles arrive instr[15:12] first, which matches decode's opcode-first order.
- PC tracking: 2b nibble count increments on every DATA cycle. When count==3, pc increments by 1 next cycle. pc wraps 16'hFFFF -> 16'h0000 and the SRAM's sequential read wraps its 128KB array identically, so no restart is needed.
- Latency: redirect sampled in cycle T gives IDLE at T+1, CMD at T+2..T+3, ADDR at T+4..T+9, DUMMY at T+10..T+(9+DUMMY_CYCLES), and the first valid nibble at T+10+DUMMY_CYCLES (T+12 by default). After reset release the sequence is identical, with IDLE as the first cycle.
- Redirect in any state: next state IDLE; pc <= i_fch_redirect_pc; nibble count <= 0. o_fch_enc_vld is combinationally masked to 0 in the redirect cycle itself, so no partial stale instruction reaches decode.
- Consecutive redirects: the latest target wins, and the sequence restarts from IDLE each time.
- Reset mid-operation: asynchronously forces cs_n=1 and oe=0 immediately, aborting the SRAM transaction.
- o_fch_pc is held constant across all 4 nibbles of an instruction.
- o_fch_pc during non-DATA states equals the pending target and is don't-care for decode.

Decomposition:
- idli_pkg gets the fetch state enum (fch_state_t) and localparam SQI_ADDR_NIBBLES=6.
- Reuse the existing sqi_data_t.
- READ_CMD stays a module parameter.
- No sub-module; the counter, address shift and state logic are flat in idli_sqi_fetch_m (about 150-200 lines).

Test Plan:
- Reset with RESET_PC=0 -> IDLE cs_n=1 for 1 cycle, then sqi_out 0x0,0x3, then 0x0 x6 with oe=1, 2 dummy cycles with oe=0, first enc_vld at cycle 12.
- Redirect to 16'h1234 during DATA -> enc_vld=0 that cycle, IDLE next, address nibbles 0,0,2,4,6,8, o_fch_pc=16'h1234 on first data nibble.
- Stream 12 SRAM nibbles 0xA..,0xB..,0xC.. from pc=16'h0010 -> enc_vld continuous, o_fch_pc 0x0010/0x0011/0x0012, each held exactly 4 cycles.
- Start at pc=16'hFFFF, stream 8 nibbles -> o_fch_pc goes 16'hFFFF then 16'h0000 with no cs_n toggle.
- Redirect to 0x0040 in ADDR cycle 3, then again to 0x0080 in CMD -> only the 0x0080 address is emitted (nibbles 0,0,0,1,0,0) and cs_n pulses high once per redirect.
- Assert rst_n low mid-DATA -> cs_n=1, oe=0, enc_vld=0 immediately; after release the RESET_PC sequence restarts from IDLE.
